// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation set and the built-in sum program.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // SUB only exists in the register form; the immediate form reuses bit 30 as immediate data.
  function automatic alu_op_e decode_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      default:  return a & b;
    endcase
  endfunction

  // Sum of 1..10 into x10, then spin on a self-jump at 0x18.
  function automatic logic [31:0] sum_prog_word(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'h0000_0513;
      32'd1:   return 32'h0010_0593;
      32'd2:   return 32'h00A0_0613;
      32'd3:   return 32'h00B5_0533;
      32'd4:   return 32'h0015_8593;
      32'd5:   return 32'hFEB6_5CE3;
      32'd6:   return 32'h0000_006F;
      default: return NOP_INSN;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 32 x 32-bit register file: two asynchronous reads, one synchronous write, x0 hardwired to zero.
module core_regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  reg [31:0] regfile [0:31];

  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regfile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regfile[rs2_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 32'h0;
    end else if (we && rd_addr != 5'd0) begin
      regfile[rd_addr] <= rd_data;
    end
  end

endmodule

// File: rtl/core.sv
// Single-cycle RV32I core with constant instruction ROM and word-addressed data RAM.
module core
  import rv32i_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter string       IMEM_INIT  = "",
  // Image for the first 32 ROM words, used whenever IMEM_INIT names a program.
  parameter logic [31:0] IMEM_PROG [0:31] = '{default: NOP_INSN}
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out
);

  localparam bit USE_BUILTIN = (IMEM_INIT == "");
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc, pc_next, pc_plus4, instr, imem_idx;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, wb_data;
  logic [31:0] mem_addr, dmem_rdata;
  logic [DAW-1:0] dmem_idx;
  logic        rf_we, mem_we, br_taken;
  alu_op_e     alu_op;

  logic [31:0] dmem [0:DMEM_DEPTH-1];

  assign imem_idx = (pc >> 2) % 32'(IMEM_DEPTH);

  always_comb begin
    if (USE_BUILTIN)          instr = sum_prog_word(imem_idx);
    else if (imem_idx < 32)   instr = IMEM_PROG[imem_idx[4:0]];
    else                      instr = NOP_INSN;
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alt    = (instr[31:25] == F7_ALT);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  core_regfile regs (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (wb_data)
  );

  assign pc_plus4   = pc + 32'd4;
  assign alu_y      = alu_eval(alu_op, rs1_val, alu_b);
  assign mem_addr   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign dmem_idx   = DAW'((mem_addr >> 2) % 32'(DMEM_DEPTH));
  assign dmem_rdata = dmem[dmem_idx];

  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Unrecognised opcodes and load/store widths fall through as NOPs.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rs2_val;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    wb_data = alu_y;
    pc_next = pc_plus4;
    case (opcode)
      OPC_LUI:   begin rf_we = 1'b1; wb_data = imm_u; end
      OPC_AUIPC: begin rf_we = 1'b1; wb_data = pc + imm_u; end
      OPC_JAL:   begin rf_we = 1'b1; wb_data = pc_plus4; pc_next = pc + imm_j; end
      OPC_JALR:  begin rf_we = 1'b1; wb_data = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'h1; end
      OPC_BRANCH: if (br_taken) pc_next = pc + imm_b;
      OPC_LOAD:  if (f3 == F3_LW) begin rf_we = 1'b1; wb_data = dmem_rdata; end
      OPC_STORE: if (f3 == F3_SW) mem_we = 1'b1;
      OPC_OP_IMM: begin rf_we = 1'b1; alu_b = imm_i; alu_op = decode_alu(f3, alt, 1'b0); end
      OPC_OP:    begin rf_we = 1'b1; alu_op = decode_alu(f3, alt, 1'b1); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  // Data RAM is not cleared by reset; a reset edge only suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) dmem[dmem_idx] <= rs2_val;
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_core.sv
// Bench for core: built-in sum program plus a corner-case program, both against ISA-level models.
module tb_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s = 1'b1;
  logic        rst_t = 1'b1;
  logic [31:0] pc_s, pc_t;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [31:0] TEST_PROG [0:31] = '{
    0:  enc_i(12'd5,   5'd0, 3'd0, 5'd0, 7'h13),   // addi x0,x0,5
    1:  enc_i(12'd1,   5'd0, 3'd0, 5'd1, 7'h13),   // addi x1,x0,1
    2:  enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd2),      // sub x2,x0,x1
    3:  enc_u(20'h80000, 5'd3, 7'h37),             // lui x3,0x80000
    4:  enc_i(12'h41F, 5'd3, 3'd5, 5'd4, 7'h13),   // srai x4,x3,31
    5:  enc_b(13'd8, 5'd2, 5'd1, 3'd6),            // bltu x1,x2,+8
    6:  enc_i(12'd99,  5'd0, 3'd0, 5'd6, 7'h13),   // addi x6,x0,99 (skipped)
    7:  enc_u(20'hDEADC, 5'd7, 7'h37),             // lui x7,0xDEADC
    8:  enc_i(12'hEEF, 5'd7, 3'd0, 5'd7, 7'h13),   // addi x7,x7,-0x111
    9:  enc_i(12'h040, 5'd0, 3'd0, 5'd8, 7'h13),   // addi x8,x0,0x40
    10: enc_s(12'd0, 5'd7, 5'd8),                  // sw x7,0(x8)
    11: enc_i(12'd0,   5'd8, 3'd2, 5'd5, 7'h03),   // lw x5,0(x8)
    12: enc_j(21'd0, 5'd0),                        // jal x0,0
    default: 32'h0000_0013
  };

  core u_sum (.clk(clk), .reset(rst_s), .pc_out(pc_s));
  core #(.IMEM_INIT("selftest"), .IMEM_PROG(TEST_PROG)) u_tst (.clk(clk), .reset(rst_t), .pc_out(pc_t));

  logic [31:0] sm_pc, tm_pc;
  logic [31:0] sm_x [0:31];
  logic [31:0] tm_x [0:31];
  logic [31:0] tm_mem [int];

  // One edge of the sum program, modelled by what each program line means.
  task automatic sum_edge(input logic r);
    rst_s = r;
    @(posedge clk); #1;
    if (r) begin
      sm_pc = 32'h0;
      for (int i = 0; i < 32; i++) sm_x[i] = 32'h0;
    end else begin
      case (sm_pc)
        32'h00: sm_x[10] = 32'd0;
        32'h04: sm_x[11] = 32'd1;
        32'h08: sm_x[12] = 32'd10;
        32'h0C: sm_x[10] = sm_x[10] + sm_x[11];
        32'h10: sm_x[11] = sm_x[11] + 32'd1;
        default: ;
      endcase
      if (sm_pc == 32'h14) sm_pc = ($signed(sm_x[12]) >= $signed(sm_x[11])) ? 32'h0C : 32'h18;
      else if (sm_pc != 32'h18) sm_pc = sm_pc + 32'd4;
    end
  endtask

  task automatic tst_edge(input logic r);
    rst_t = r;
    @(posedge clk); #1;
    if (r) begin
      tm_pc = 32'h0;
      for (int i = 0; i < 32; i++) tm_x[i] = 32'h0;
    end else begin
      case (tm_pc >> 2)
        32'd1:  tm_x[1] = 32'd1;
        32'd2:  tm_x[2] = 32'd0 - tm_x[1];
        32'd3:  tm_x[3] = 32'h8000_0000;
        32'd4:  tm_x[4] = $signed(tm_x[3]) >>> 31;
        32'd6:  tm_x[6] = 32'd99;
        32'd7:  tm_x[7] = 32'hDEAD_C000;
        32'd8:  tm_x[7] = tm_x[7] - 32'h111;
        32'd9:  tm_x[8] = 32'h40;
        32'd10: tm_mem[int'(tm_x[8] >> 2)] = tm_x[7];
        32'd11: tm_x[5] = tm_mem[int'(tm_x[8] >> 2)];
        default: ;
      endcase
      if (tm_pc == 32'h14) tm_pc = (tm_x[1] < tm_x[2]) ? 32'h1C : 32'h18;
      else if (tm_pc != 32'h30) tm_pc = tm_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    for (int e = 0; e < 2; e++) begin
      sum_edge(1'b1);
      checks++;
      if (pc_s !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc_s, 32'h0);
      else passed++;
      for (int r = 10; r <= 12; r++) begin
        checks++;
        if (u_sum.regs.regfile[r] !== 32'h0)
          $display("FAIL reset_x%0d: got %h expected %h", r, u_sum.regs.regfile[r], 32'h0);
        else passed++;
      end
    end
    sum_edge(1'b0);
    checks++;
    if (pc_s !== 32'h4) $display("FAIL first_edge_pc: got %h expected %h", pc_s, 32'h4);
    else passed++;
  endtask

  task automatic test_sum_init();
    logic [31:0] exp_r [0:2];
    exp_r = '{32'h0, 32'h1, 32'hA};
    sum_edge(1'b0);
    sum_edge(1'b0);
    checks++;
    if (pc_s !== 32'hC) $display("FAIL init_pc: got %h expected %h", pc_s, 32'hC);
    else passed++;
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (u_sum.regs.regfile[10+r] !== exp_r[r])
        $display("FAIL init_x%0d: got %h expected %h", 10 + r, u_sum.regs.regfile[10+r], exp_r[r]);
      else passed++;
    end
  endtask

  task automatic test_loop_progress();
    repeat (3) sum_edge(1'b0);
    checks++;
    if (pc_s !== 32'hC) $display("FAIL loop_pc: got %h expected %h", pc_s, 32'hC);
    else passed++;
    checks++;
    if (u_sum.regs.regfile[10] !== 32'h1) $display("FAIL loop_x10: got %h expected %h", u_sum.regs.regfile[10], 32'h1);
    else passed++;
    checks++;
    if (u_sum.regs.regfile[11] !== 32'h2) $display("FAIL loop_x11: got %h expected %h", u_sum.regs.regfile[11], 32'h2);
    else passed++;
  endtask

  task automatic test_completion();
    logic [31:0] exp_r [0:2];
    exp_r = '{32'h37, 32'hB, 32'hA};
    for (int e = 7; e <= 50; e++) begin
      sum_edge(1'b0);
      checks++;
      if (pc_s !== sm_pc) $display("FAIL run_pc edge %0d: got %h expected %h", e, pc_s, sm_pc);
      else passed++;
      if (e == 33 || e == 50) begin
        checks++;
        if (pc_s !== 32'h18) $display("FAIL done_pc edge %0d: got %h expected %h", e, pc_s, 32'h18);
        else passed++;
        for (int r = 0; r < 3; r++) begin
          checks++;
          if (u_sum.regs.regfile[10+r] !== exp_r[r])
            $display("FAIL done_x%0d edge %0d: got %h expected %h", 10 + r, e, u_sum.regs.regfile[10+r], exp_r[r]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_random_reset();
    for (int t = 0; t < 6; t++) begin
      int n_rst;
      int n_run;
      n_rst = $urandom_range(1, 3);
      n_run = $urandom_range(1, 40);
      repeat (n_rst) sum_edge(1'b1);
      checks++;
      if (pc_s !== 32'h0) $display("FAIL midreset_pc trial %0d: got %h expected %h", t, pc_s, 32'h0);
      else passed++;
      for (int r = 10; r <= 12; r++) begin
        checks++;
        if (u_sum.regs.regfile[r] !== 32'h0)
          $display("FAIL midreset_x%0d trial %0d: got %h expected %h", r, t, u_sum.regs.regfile[r], 32'h0);
        else passed++;
      end
      for (int e = 0; e < n_run; e++) begin
        sum_edge(1'b0);
        checks++;
        if (pc_s !== sm_pc) $display("FAIL rand_pc trial %0d: got %h expected %h", t, pc_s, sm_pc);
        else passed++;
        for (int r = 10; r <= 12; r++) begin
          checks++;
          if (u_sum.regs.regfile[r] !== sm_x[r])
            $display("FAIL rand_x%0d trial %0d: got %h expected %h", r, t, u_sum.regs.regfile[r], sm_x[r]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_alu_corners();
    tst_edge(1'b1);
    for (int e = 0; e < 14; e++) begin
      tst_edge(1'b0);
      checks++;
      if (pc_t !== tm_pc) $display("FAIL corner_pc edge %0d: got %h expected %h", e, pc_t, tm_pc);
      else passed++;
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (u_tst.regs.regfile[r] !== tm_x[r])
        $display("FAIL corner_x%0d: got %h expected %h", r, u_tst.regs.regfile[r], tm_x[r]);
      else passed++;
    end
    checks++;
    if (u_tst.regs.regfile[2] !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h expected %h", u_tst.regs.regfile[2], 32'hFFFF_FFFF);
    else passed++;
    checks++;
    if (u_tst.regs.regfile[4] !== 32'hFFFF_FFFF) $display("FAIL srai_31: got %h expected %h", u_tst.regs.regfile[4], 32'hFFFF_FFFF);
    else passed++;
    checks++;
    if (u_tst.regs.regfile[6] !== 32'h0) $display("FAIL bltu_taken: got %h expected %h", u_tst.regs.regfile[6], 32'h0);
    else passed++;
  endtask

  task automatic test_memory();
    int k;
    checks++;
    if (u_tst.regs.regfile[5] !== 32'hDEAD_BEEF) $display("FAIL lw_x5: got %h expected %h", u_tst.regs.regfile[5], 32'hDEAD_BEEF);
    else passed++;
    checks++;
    if (u_tst.dmem[16] !== 32'hDEAD_BEEF) $display("FAIL sw_word: got %h expected %h", u_tst.dmem[16], 32'hDEAD_BEEF);
    else passed++;
    checks++;
    if (pc_t !== 32'h30) $display("FAIL halt_pc: got %h expected %h", pc_t, 32'h30);
    else passed++;
    tst_edge(1'b1);
    k = $urandom_range(2, 10);
    repeat (k) tst_edge(1'b0);
    tst_edge(1'b1);
    checks++;
    if (pc_t !== 32'h0) $display("FAIL abort_pc: got %h expected %h", pc_t, 32'h0);
    else passed++;
    for (int r = 0; r < 9; r++) begin
      checks++;
      if (u_tst.regs.regfile[r] !== 32'h0)
        $display("FAIL abort_x%0d: got %h expected %h", r, u_tst.regs.regfile[r], 32'h0);
      else passed++;
    end
    checks++;
    if (u_tst.dmem[16] !== 32'hDEAD_BEEF) $display("FAIL ram_kept: got %h expected %h", u_tst.dmem[16], 32'hDEAD_BEEF);
    else passed++;
    repeat (14) tst_edge(1'b0);
    checks++;
    if (u_tst.regs.regfile[5] !== tm_x[5]) $display("FAIL rerun_x5: got %h expected %h", u_tst.regs.regfile[5], tm_x[5]);
    else passed++;
    checks++;
    if (pc_t !== tm_pc) $display("FAIL rerun_pc: got %h expected %h", pc_t, tm_pc);
    else passed++;
  endtask

  initial begin
    sm_pc = 32'h0;
    tm_pc = 32'h0;
    for (int i = 0; i < 32; i++) begin
      sm_x[i] = 32'h0;
      tm_x[i] = 32'h0;
    end
    test_reset();
    test_sum_init();
    test_loop_progress();
    test_completion();
    test_random_reset();
    test_alu_corners();
    test_memory();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/core.md
Name: core

Overview:
- Single-cycle RV32I integer core with internal instruction ROM and data RAM; the top-level CPU block of the design.
- Every rising clock edge after reset retires exactly one instruction.
- The ROM is preloaded with the default program: sum of the first 10 natural numbers.
- Exposes only the current program counter (PC); architectural registers are reached hierarchically through instance `regs` (array `regfile[0:31]`).

Parameters:
- IMEM_DEPTH, 256, instruction ROM depth in 32-bit words.
- DMEM_DEPTH, 256, data RAM depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_INIT, "", hex file for the ROM. When empty, the built-in sum program is used.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous active-high reset.
- pc_out  output  32  PC of the instruction executing this cycle (register value).

Behaviour:
- Reset: synchronous, active-high. On a clk edge with reset=1:
  - PC <= RESET_PC, so pc_out=0.
  - All regfile[0..31] <= 0.
  - Data RAM contents are unaffected.
- Reset asserted mid-program aborts execution; no register or memory writes occur on that edge.
- Execution: single cycle. Fetch from imem[PC[31:2]], decode, execute, then writeback and PC update, all on the same edge. Latency is 1 cycle per instruction.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LW, SW (word only; address bits [1:0] ignored).
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Any other opcode (FENCE, SYSTEM, illegal): NOP, PC+4.
- Arithmetic: 32-bit, wrap-around, no overflow trap.
  - Shifts use operand bits [4:0].
  - Immediates are sign-extended per RV32I formats.
- x0: reads return 0; writes are discarded.
- Regfile: two asynchronous read ports, one synchronous write port. A read of rd during its own write cycle returns the old value.
- Data RAM: synchronous write and asynchronous read. Addresses are taken modulo DMEM_DEPTH.
- ROM: addresses are taken modulo IMEM_DEPTH. Unused ROM words are 0x00000013 (NOP).
- Built-in program (byte address: instruction):
  - 0x00: addi x10,x0,0
  - 0x04: addi x11,x0,1
  - 0x08: addi x12,x0,10
  - 0x0C: add x10,x10,x11
  - 0x10: addi x11,x11,1
  - 0x14: bge x12,x11,-8 (to 0x0C)
  - 0x18: jal x0,0 (halt loop)
- Halt: after the program finishes, PC stays at 0x18 indefinitely and registers hold their values.

Decomposition:
- Shared package `rv32i_pkg`:
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - funct3/funct7 constants.
  - ALU-op enum.
  - NOP encoding.
- One natural sub-module: `core_regfile`, instantiated as `regs`, with storage `reg [31:0] regfile[0:31]` so verification can probe `regs.regfile[n]`.
- ALU, decoder and memories stay inline in `core`.

Test Plan:
- Reset: hold reset for 2 edges, then release. Required:
  - pc_out=0 and x10=x11=x12=0 while reset is held.
  - First edge after release: pc_out=0x04.
- Sum program, init phase: after 3 edges, x10=0, x11=1, x12=0x0A, pc_out=0x0C.
- Loop progress: after 6 edges, x10=1, x11=2, pc_out=0x0C (branch taken).
- Completion: after 33 edges, x10=0x37, x11=0x0B, x12=0x0A, pc_out=0x18. At edge 50, values are unchanged and pc_out is still 0x18.
- x0 and ALU/branch corners, via an IMEM_INIT program:
  - `addi x0,x0,5` leaves x0=0.
  - `sub` of 0-1 gives 0xFFFFFFFF.
  - `srai` of 0x80000000 by 31 gives 0xFFFFFFFF.
  - `bltu` with 1 vs 0xFFFFFFFF is taken.
- Memory: `sw` 0xDEADBEEF to address 0x40, then `lw` from 0x40 into x5 → x5=0xDEADBEEF. Asserting reset mid-program returns pc_out to 0 and zeroes registers on the next edge.
